// File: rtl/reg_readback_pkg.sv
// Shared types and constants for the register readback transmitter.
// Holds the serializer state encoding, frame geometry and the burst length decode.
package reg_readback_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = FRAME_BITS - 2;
  localparam int REG_BYTES  = 16;

  // A zero count on the request means a full-bank readback.
  function automatic logic [4:0] decode_count(input logic [3:0] cnt);
    return (cnt == 4'd0) ? 5'(REG_BYTES) : {1'b0, cnt};
  endfunction

endpackage

// File: rtl/reg_readback_if.sv
// Host-side request bus and serial status of the register readback transmitter.
// The host owns the register image and request fields; the transmitter owns the rest.
interface reg_readback_if;
  import reg_readback_pkg::*;

  logic [8*REG_BYTES-1:0] reg_data;
  logic [3:0]             rd_addr;
  logic [3:0]             rd_count;
  logic                   rd_valid;
  logic                   rd_ready;
  logic                   tx;
  logic                   busy;
  logic                   done;

  modport master (
    output reg_data, rd_addr, rd_count, rd_valid,
    input  rd_ready, tx, busy, done
  );

  modport slave (
    input  reg_data, rd_addr, rd_count, rd_valid,
    output rd_ready, tx, busy, done
  );

endinterface

// File: rtl/reg_readback_uart_tx_frame.sv
// Single 8N1 frame serializer: load starts the start bit on the next edge, frame_done flags the last stop-bit cycle.
// A load presented with frame_done chains the next frame with no idle gap.
module uart_tx_frame
  import reg_readback_pkg::*;
#(
  parameter int CLKS_PER_BIT = 186
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] byte_dat,
  output logic       tx,
  output logic       frame_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  tx_state_t        state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             bit_end;

  assign bit_end    = (bit_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign frame_done = (state == STOP) && bit_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      bit_cnt <= bit_end ? '0 : bit_cnt + 1'b1;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (load) begin
            state <= START;
            tx    <= 1'b0;
            shreg <= byte_dat;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            tx      <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            // Chained load goes straight into the next start bit.
            if (load) begin
              state <= START;
              tx    <= 1'b0;
              shreg <= byte_dat;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/reg_readback.sv
// Register readback transmitter: snapshots 16 bytes on request and sends a wrapping run as back-to-back 8N1 frames.
// Start bit one cycle after acceptance; requests while busy are dropped. READBACK_CHECKSUM_EN appends an XOR frame.
module reg_readback
  import reg_readback_pkg::*;
#(
  parameter int CLKS_PER_BIT = 186
) (
  input  logic           clk,
  input  logic           reset,
  reg_readback_if.slave  bus
);

  logic [REG_BYTES-1:0][7:0] snap;
  logic [3:0]                ptr;
  logic [3:0]                next_ptr;
  logic [4:0]                rem;
  logic                      ready_r;
  logic                      busy_r;
  logic                      done_r;
  logic                      accept;
  logic                      load;
  logic                      finish;
  logic [7:0]                load_byte;
  logic                      frame_done;
  logic                      tx_line;

`ifdef READBACK_CHECKSUM_EN
  logic [7:0]                csum;
  logic                      csum_sent;
`endif

  assign accept   = bus.rd_valid && ready_r;
  assign next_ptr = ptr + 4'd1;

  always_comb begin
    load      = 1'b0;
    finish    = 1'b0;
    load_byte = snap[next_ptr];
    if (accept) begin
      // First byte comes straight from the live image; the snapshot lands on the same edge.
      load      = 1'b1;
      load_byte = bus.reg_data[{bus.rd_addr, 3'b000} +: 8];
    end else if (busy_r && frame_done) begin
      if (rem > 5'd1) begin
        load = 1'b1;
      end else begin
`ifdef READBACK_CHECKSUM_EN
        if (!csum_sent) begin
          load      = 1'b1;
          load_byte = csum;
        end else begin
          finish = 1'b1;
        end
`else
        finish = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      snap <= bus.reg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ptr     <= '0;
      rem     <= '0;
    end else begin
      done_r <= finish;
      if (accept) begin
        ptr     <= bus.rd_addr;
        rem     <= decode_count(bus.rd_count);
        busy_r  <= 1'b1;
        ready_r <= 1'b0;
      end else if (busy_r && frame_done && rem > 5'd1) begin
        ptr <= next_ptr;
        rem <= rem - 5'd1;
      end else if (finish) begin
        busy_r  <= 1'b0;
        ready_r <= 1'b1;
      end else if (!busy_r) begin
        ready_r <= 1'b1;
      end
    end
  end

`ifdef READBACK_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      csum      <= '0;
      csum_sent <= 1'b0;
    end else if (accept) begin
      csum      <= load_byte;
      csum_sent <= 1'b0;
    end else if (busy_r && frame_done) begin
      if (rem > 5'd1) begin
        csum <= csum ^ load_byte;
      end else if (!csum_sent) begin
        csum_sent <= 1'b1;
      end
    end
  end
`endif

  uart_tx_frame #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_frame (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .byte_dat   (load_byte),
    .tx         (tx_line),
    .frame_done (frame_done)
  );

  assign bus.tx       = tx_line;
  assign bus.rd_ready = ready_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;

endmodule

// File: tb/tb_reg_readback.sv
// Bench for reg_readback at CLKS_PER_BIT=4: table of bursts plus hand sequences, UART frame decoder feeding a scoreboard.
module tb_reg_readback;

  localparam int CPB       = 4;
  localparam int FRAME_CYC = 10 * CPB;

  typedef struct {
    logic [7:0] dat;
    int         start;
  } frame_t;

  typedef struct {
    int         fill;
    logic [3:0] addr;
    logic [3:0] count;
    int         done_lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  frame_t     exp_q[$];
  int         done_q[$];
  logic [7:0] mem [16];
  vec_t       vecs [8];

  bit         mon_active = 1'b0;
  int         mon_start = 0;
  logic [9:0] mon_bits = '0;
  bit         mon_ok = 1'b1;

  reg_readback_if bus ();

  reg_readback #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test by %0t, want finish", $time);
    $fatal(1, "watchdog expired");
  end

  // UART decoder and done scoreboard
  initial begin : monitor
    int     idx;
    int     b;
    int     d;
    frame_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        mon_active = 1'b0;
      end else begin
        if (!mon_active && bus.tx === 1'b0) begin
          mon_active = 1'b1;
          mon_start  = cyc;
          mon_ok     = 1'b1;
        end
        if (mon_active) begin
          idx = cyc - mon_start;
          b   = idx / CPB;
          if (idx % CPB == 0) mon_bits[b] = bus.tx;
          else if (bus.tx !== mon_bits[b]) mon_ok = 1'b0;
          if (idx == FRAME_CYC - 1) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL frame_unexpected: got bits=%b at cycle %0d, want no frame", mon_bits, mon_start);
            end else begin
              e = exp_q.pop_front();
              if (mon_bits !== {1'b1, e.dat, 1'b0} || !mon_ok || mon_start != e.start) begin
                errors++;
                $display("FAIL frame: got bits=%b start=%0d steady=%0d, want bits=%b start=%0d steady=1",
                         mon_bits, mon_start, mon_ok, {1'b1, e.dat, 1'b0}, e.start);
              end
            end
            mon_active = 1'b0;
          end
        end
        if (bus.done === 1'b1) begin
          checks++;
          if (done_q.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected: got done=1 at cycle %0d, want done=0", cyc);
          end else begin
            d = done_q.pop_front();
            if (cyc != d || bus.busy !== 1'b0 || bus.rd_ready !== 1'b1) begin
              errors++;
              $display("FAIL done: got cycle=%0d busy=%b rd_ready=%b, want cycle=%0d busy=0 rd_ready=1",
                       cyc, bus.busy, bus.rd_ready, d);
            end
          end
        end else if (done_q.size() > 0 && cyc > done_q[0]) begin
          checks++;
          errors++;
          $display("FAIL done_missing: got no done by cycle %0d, want done at cycle %0d", cyc, done_q[0]);
          void'(done_q.pop_front());
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic set_mem(input int fill);
    for (int k = 0; k < 16; k++) begin
      case (fill)
        1:       mem[k] = 8'($urandom);
        default: mem[k] = 8'(k);
      endcase
    end
    if (fill == 2) begin
      mem[3]  = 8'h5A;
      mem[15] = 8'hF0;
      mem[0]  = 8'h0F;
    end
    if (fill == 3) begin
      mem[0] = 8'h12;
      mem[1] = 8'h34;
    end
    for (int k = 0; k < 16; k++) bus.reg_data[8*k +: 8] = mem[k];
  endtask

  // Pulse rd_valid for one cycle; when acceptance is expected, queue the frames and the done cycle.
  task automatic req(input logic [3:0] a, input logic [3:0] c, input bit accept, input int done_lat);
    int         n;
    int         na;
    int         lat;
    logic [7:0] x;
    logic [7:0] bt;
    @(negedge clk);
    bus.rd_addr  = a;
    bus.rd_count = c;
    bus.rd_valid = 1'b1;
    chk("rd_ready_at_request", 32'(bus.rd_ready), 32'(accept));
    if (accept) begin
      na  = cyc + 1;
      n   = (c == 4'd0) ? 16 : int'(c);
      x   = 8'h00;
      lat = done_lat;
      for (int i = 0; i < n; i++) begin
        bt = mem[(int'(a) + i) % 16];
        x  = x ^ bt;
        exp_q.push_back('{bt, na + i * FRAME_CYC});
      end
`ifdef READBACK_CHECKSUM_EN
      exp_q.push_back('{x, na + n * FRAME_CYC});
      lat = lat + FRAME_CYC;
`endif
      done_q.push_back(na - 1 + lat);
    end
    @(negedge clk);
    bus.rd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0 || mon_active) && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d frames and %0d dones outstanding, want 0", exp_q.size(), done_q.size());
      exp_q.delete();
      done_q.delete();
    end
  endtask

  initial begin
    int n;
    vecs[0] = '{2, 4'd3,  4'd1,  41};
    vecs[1] = '{2, 4'd15, 4'd2,  81};
    vecs[2] = '{0, 4'd0,  4'd0,  641};
    vecs[3] = '{3, 4'd0,  4'd2,  81};
    vecs[4] = '{1, 4'd9,  4'd0,  641};
    vecs[5] = '{1, 4'd13, 4'd5,  201};
    vecs[6] = '{1, 4'd1,  4'd15, 601};
    vecs[7] = '{1, 4'd6,  4'd3,  121};

    bus.rd_valid = 1'b0;
    bus.rd_addr  = '0;
    bus.rd_count = '0;
    bus.reg_data = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_tx", 32'(bus.tx), 32'd1);
    chk("reset_rd_ready", 32'(bus.rd_ready), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #2;
    chk("rd_ready_after_reset", 32'(bus.rd_ready), 32'd1);

    for (int v = 0; v < 8; v++) begin
      set_mem(vecs[v].fill);
      req(vecs[v].addr, vecs[v].count, 1'b1, vecs[v].done_lat);
      chk("busy_in_burst", 32'(bus.busy), 32'd1);
      wait_idle(800);
      repeat (2) @(negedge clk);
    end

    // New request in the done cycle: start bit must follow one cycle later.
    set_mem(1);
    req(4'd2, 4'd1, 1'b1, 41);
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL b2b_done_wait: got no done in 100 cycles, want done");
    end
    req(4'd5, 4'd2, 1'b1, 81);
    wait_idle(300);
    repeat (3) @(negedge clk);

    // Snapshot isolation and dropped request while busy.
    set_mem(0);
    mem[4] = 8'hA5;
    bus.reg_data[39:32] = 8'hA5;
    req(4'd4, 4'd1, 1'b1, 41);
    repeat (8) @(negedge clk);
    bus.reg_data[39:32] = 8'h3C;
    chk("busy_mid_burst", 32'(bus.busy), 32'd1);
    req(4'd4, 4'd1, 1'b0, 41);
    wait_idle(200);
    repeat (50) @(negedge clk);

    // Reset in the middle of a data bit.
    set_mem(1);
    req(4'd0, 4'd3, 1'b1, 121);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    done_q.delete();
    @(posedge clk);
    #2;
    chk("reset_mid_tx", 32'(bus.tx), 32'd1);
    chk("reset_mid_done", 32'(bus.done), 32'd0);
    chk("reset_mid_busy", 32'(bus.busy), 32'd0);
    chk("reset_mid_rd_ready", 32'(bus.rd_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #2;
    chk("rd_ready_after_release", 32'(bus.rd_ready), 32'd1);
    repeat (60) @(negedge clk);
    chk("tx_idle_after_reset", 32'(bus.tx), 32'd1);

    checks++;
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d frames %0d dones pending, want 0", exp_q.size(), done_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
